// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, rate table and divisor helper.
// UART_RX_PARITY_EN adds the parity state for 8E1 framing.
package uart_pkg;

    localparam int unsigned SAMPLING_FACTOR = 16;

    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } rx_state_e;

    // Rounded clock cycles per oversample tick.
    function automatic int unsigned baud_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud,
                                                 input int unsigned scale);
        return (clk_freq + (baud * scale) / 2) / (baud * scale);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick divider. The rate is chosen by baud_sel, latched only while the
// receiver idles; restart realigns the tick phase to a detected start edge.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned SCALE    = SAMPLING_FACTOR
) (
    input  logic       src_clk,
    input  logic       rst_n,
    input  logic       latch,
    input  logic       restart,
    input  logic [1:0] baud_sel,
    output logic       tick
);

    localparam int unsigned DIV_MAX = baud_divisor(CLK_FREQ, BAUD_9600, SCALE);
    localparam int unsigned CNT_W   = $clog2(DIV_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_M1_9600   =
        CNT_W'(baud_divisor(CLK_FREQ, BAUD_9600, SCALE) - 1);
    localparam logic [CNT_W-1:0] DIV_M1_19200  =
        CNT_W'(baud_divisor(CLK_FREQ, BAUD_19200, SCALE) - 1);
    localparam logic [CNT_W-1:0] DIV_M1_57600  =
        CNT_W'(baud_divisor(CLK_FREQ, BAUD_57600, SCALE) - 1);
    localparam logic [CNT_W-1:0] DIV_M1_115200 =
        CNT_W'(baud_divisor(CLK_FREQ, BAUD_115200, SCALE) - 1);

    logic [1:0]       baud_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, div_m1;

    always_comb begin
        case (baud_q)
            2'b00:   div_m1 = DIV_M1_9600;
            2'b01:   div_m1 = DIV_M1_19200;
            2'b10:   div_m1 = DIV_M1_57600;
            default: div_m1 = DIV_M1_115200;
        endcase
    end

    // >= lets the counter recover if a slower-to-faster switch leaves it past the limit.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || cnt_q >= div_m1) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_q == div_m1);

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= 2'b00;
            cnt_q  <= '0;
        end else begin
            if (latch) begin
                baud_q <= baud_sel;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver on the system clock: oversampled, 3-sample majority vote per bit,
// one-cycle valid/error pulses. Define UART_RX_PARITY_EN for 8E1; default is 8N1.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned SCALE    = SAMPLING_FACTOR
) (
    input  logic       src_clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] baud_sel,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       bussy
);

    localparam int unsigned    TCW       = $clog2(SCALE);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(SCALE - 1);
    localparam logic [TCW-1:0] SMP_FIRST = TCW'(SCALE / 2 - 1);
    localparam logic [TCW-1:0] SMP_MID   = TCW'(SCALE / 2);
    localparam logic [TCW-1:0] SMP_LAST  = TCW'(SCALE / 2 + 1);

    logic           rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e      state_q, state_d;
    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [1:0]     smp_q, smp_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d, ferr_q, ferr_d;
    logic           idle, tick, start_det, last_smp, vote;
`ifdef UART_RX_PARITY_EN
    logic           par_q, par_d, perr_q, perr_d;
`endif

    assign idle      = (state_q == StIdle);
    assign start_det = idle && ena && rx_prev_q && !rx_sync_q;
    assign last_smp  = tick && (tick_cnt_q == SMP_LAST);
    assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);

    uart_rx_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .SCALE    (SCALE)
    ) u_tick_gen (
        .src_clk  (src_clk),
        .rst_n    (rst_n),
        .latch    (idle),
        .restart  (start_det),
        .baud_sel (baud_sel),
        .tick     (tick)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        smp_d      = smp_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
`endif

        if (!idle && tick) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TCW'(1);
            if (tick_cnt_q == SMP_FIRST) smp_d[0] = rx_sync_q;
            if (tick_cnt_q == SMP_MID)   smp_d[1] = rx_sync_q;
        end

        unique case (state_q)
            StIdle: begin
                if (start_det) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            StStart: begin
                if (last_smp) state_d = vote ? StIdle : StData;
            end
            StData: begin
                if (last_smp) begin
                    shift_d   = {vote, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (last_smp) begin
                    par_d   = vote;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (last_smp) begin
                    if (vote) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_q ^ (^shift_q);
`endif
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!ena) begin
            state_d   = StIdle;
            shift_d   = '0;
            bit_cnt_d = '0;
            data_d    = data_q;
            valid_d   = 1'b0;
            ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            smp_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx_in;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            smp_q      <= smp_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign bussy      = !idle;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed plus randomized bench for uart_rx_oversample with a frame-level reference model.
// Honours UART_RX_PARITY_EN for 8E1 framing.
module tb_uart_rx_oversample;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned SCALE    = 16;

    logic       src_clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] baud_sel;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid, frame_err, parity_err, bussy;

    int checks = 0;
    int failures = 0;
    int cur_div;
    logic lat_b2, lat_b3;

    // Monitor record and model expectation per accepted byte: {parity_err, data}.
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int ferr_cnt = 0, perr_alone = 0, valid_busy = 0;
    int exp_ferr = 0;
    logic [7:0] exp_data = 8'h00;

    uart_rx_oversample #(
        .CLK_FREQ (CLK_FREQ),
        .SCALE    (SCALE)
    ) dut (
        .src_clk    (src_clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .baud_sel   (baud_sel),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .bussy      (bussy)
    );

    always #5 src_clk = ~src_clk;

    always @(negedge src_clk) begin
        if (data_valid) begin
            got_q.push_back({parity_err, data_out});
            if (bussy) valid_busy++;
        end
        if (frame_err) ferr_cnt++;
        if (parity_err && !data_valid) perr_alone++;
    end

    function automatic int div_for(input logic [1:0] sel);
        int baud;
        case (sel)
            2'b00:   baud = 9600;
            2'b01:   baud = 19200;
            2'b10:   baud = 57600;
            default: baud = 115200;
        endcase
        return (int'(CLK_FREQ) + baud * int'(SCALE) / 2) / (baud * int'(SCALE));
    endfunction

    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        if (stop_ok) begin
            exp_q.push_back({~par_ok, d});
            exp_data = d;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_scoreboard(input string tag);
        check({tag, " valid count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, " {perr,byte}"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
        check({tag, " frame_err count"}, 32'(ferr_cnt), 32'(exp_ferr));
        check({tag, " data_out"}, 32'(data_out), 32'(exp_data));
        check({tag, " bussy idle"}, 32'(bussy), 32'd0);
        check({tag, " stray parity_err"}, 32'(perr_alone), 32'd0);
        check({tag, " bussy at valid"}, 32'(valid_busy), 32'd0);
    endtask

    task automatic drive_bits(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge src_clk);
    endtask

    task automatic idle_gap();
        drive_bits(1'b1, int'($urandom_range(4, 40)));
    endtask

    // Good stop bits are cut to 3/4 so a following frame starts in the stop tail.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par_flip,
                              input int glitch_bit);
        int bt = int'(SCALE) * cur_div;
        int gs = int'(SCALE / 2) * cur_div + cur_div / 2;
        rx_in = 1'b0;
        repeat (2) @(negedge src_clk);
        lat_b2 = bussy;
        @(negedge src_clk);
        lat_b3 = bussy;
        repeat (bt - 3) @(negedge src_clk);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                // One tick low, centred on the middle vote sample of the bit.
                drive_bits(d[i], gs);
                drive_bits(1'b0, cur_div);
                drive_bits(d[i], bt - gs - cur_div);
            end else begin
                drive_bits(d[i], bt);
            end
        end
`ifdef UART_RX_PARITY_EN
        drive_bits((^d) ^ par_flip, bt);
`else
        if (par_flip) drive_bits(1'b1, 0);
`endif
        drive_bits(stop_val, stop_val ? (bt * 3) / 4 : bt);
    endtask

    initial begin
        logic [7:0] rnd;
        int bt;
        rst_n    = 1'b0;
        ena      = 1'b0;
        baud_sel = 2'b11;
        rx_in    = 1'b1;
        cur_div  = div_for(2'b11);
        bt       = int'(SCALE) * cur_div;
        repeat (3) @(negedge src_clk);
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset data_valid", 32'(data_valid), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset parity_err", 32'(parity_err), 32'd0);
        check("reset bussy", 32'(bussy), 32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (5) @(negedge src_clk);

        // Clean byte and start-detect latency.
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        model_frame(8'hA5, 1'b1, 1'b1);
        check("bussy 2 cycles after edge", 32'(lat_b2), 32'd0);
        check("bussy 3 cycles after edge", 32'(lat_b3), 32'd1);
        idle_gap();
        check_scoreboard("clean");

        // False start: 4 ticks low.
        drive_bits(1'b0, 4 * cur_div);
        drive_bits(1'b1, bt);
        check_scoreboard("false start");

        // Framing error, line low for two bit times, then recovery.
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        model_frame(8'h3C, 1'b0, 1'b1);
        drive_bits(1'b0, bt);
        drive_bits(1'b1, 20);
        check_scoreboard("framing");
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        model_frame(8'h5A, 1'b1, 1'b1);
        idle_gap();
        check_scoreboard("after break");

        // Glitch rejection on bit 3.
        send_frame(8'hFF, 1'b1, 1'b0, 3);
        model_frame(8'hFF, 1'b1, 1'b1);
        idle_gap();
        check_scoreboard("glitch");

        // ena dropped mid-frame.
        rnd = 8'($urandom);
        drive_bits(1'b0, bt);
        drive_bits(rnd[0], bt);
        drive_bits(rnd[1], bt);
        ena = 1'b0;
        @(negedge src_clk);
        check("ena drop bussy", 32'(bussy), 32'd0);
        drive_bits(1'b1, bt);
        ena = 1'b1;
        idle_gap();
        check_scoreboard("ena drop");

        // Reset during bit 4.
        rnd = 8'($urandom);
        drive_bits(1'b0, bt);
        for (int i = 0; i < 4; i++) drive_bits(rnd[i], bt);
        drive_bits(rnd[4], bt / 2);
        rst_n = 1'b0;
        #1;
        check("reset mid data_out", 32'(data_out), 32'h00);
        check("reset mid bussy", 32'(bussy), 32'd0);
        check("reset mid data_valid", 32'(data_valid), 32'd0);
        exp_data = 8'h00;
        @(negedge src_clk);
        drive_bits(1'b1, 4);
        rst_n = 1'b1;
        idle_gap();
        check_scoreboard("reset");

        // Slowest rate.
        baud_sel = 2'b00;
        cur_div  = div_for(2'b00);
        repeat (4) @(negedge src_clk);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        model_frame(8'h55, 1'b1, 1'b1);
        baud_sel = 2'b11;
        cur_div  = div_for(2'b11);
        idle_gap();
        check_scoreboard("9600");

        // Back-to-back; baud_sel changes inside the last frame must not take effect.
        send_frame(8'h00, 1'b1, 1'b0, -1);
        model_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        model_frame(8'hFF, 1'b1, 1'b1);
`ifdef UART_RX_PARITY_EN
        rnd = 8'h01;
        fork
            send_frame(rnd, 1'b1, 1'b1, -1);
            begin
                repeat (3 * bt) @(negedge src_clk);
                baud_sel = 2'b00;
            end
        join
        model_frame(rnd, 1'b1, 1'b0);
`else
        rnd = 8'($urandom);
        fork
            send_frame(rnd, 1'b1, 1'b0, -1);
            begin
                repeat (3 * bt) @(negedge src_clk);
                baud_sel = 2'b00;
            end
        join
        model_frame(rnd, 1'b1, 1'b1);
`endif
        baud_sel = 2'b11;
        idle_gap();
        check_scoreboard("back-to-back");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

Self-contained UART receiver that runs directly on the system clock, generates its own oversampling tick, majority-votes each bit, and reports received bytes with a one-cycle valid pulse plus framing/parity error flags. It sits between the board RX pin and the display/echo logic. It replaces the separately prescaled receive clock with a single clock domain and a defined handshake.

## Interface
- CLK_FREQ, 50_000_000: src_clk frequency in Hz.
- SCALE, 16: oversampling factor per bit. Must be even and ≥ 8.
- src_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  receiver enable. Low forces IDLE and suppresses all pulses.
- baud_sel  in  2  rate select: 00=9600, 01=19200, 10=57600, 11=115200.
- rx_in  in  1  asynchronous serial input; idle is high.
- data_out  out  8  last correctly received byte. Holds until the next good byte.
- data_valid  out  1  one-cycle pulse when data_out updates.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- parity_err  out  1  one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.
- bussy  out  1  high from start-bit detection until return to IDLE.

## Operation
- **Input sync:** rx_in passes through 2 flops, both reset to 1. All logic uses the synchronized value.
- **Tick generator:** divisor = round(CLK_FREQ / (baud × SCALE)). It emits a 1-cycle tick and is restarted at start detection so bit phase aligns to the falling edge.
- **Baud latch:** baud_sel is latched only in IDLE. Changes mid-frame take effect on the next frame.
- **Bit sampling:** a tick counter runs 0..SCALE-1 per bit. Samples are taken at ticks SCALE/2-1, SCALE/2 and SCALE/2+1. Bit value is the majority of the 3.
- **FSM states:**
  - IDLE: on a synced 1→0 transition with ena=1, go to START and set bussy.
  - START: majority 0 → DATA. Majority 1 (false start) → IDLE.
  - DATA: 8 bits, LSB first, into a shift register; then go to PARITY (if compiled in) or STOP.
  - PARITY: sample the parity bit, then go to STOP.
  - STOP: on the last sample, if majority 1, load data_out and pulse data_valid (and parity_err if mismatch), then go to IDLE. If majority 0, pulse frame_err, leave data_out unchanged, and go to BREAK.
  - BREAK: wait for the synced line high, then go to IDLE.
- **Parity error:** data_out and data_valid still update, alongside the parity_err pulse.
- **ena low in any state:** go to IDLE next cycle, bussy=0, shift register discarded.
- **Back-to-back frames:** after IDLE on the stop mid-sample, a falling edge in the remaining half stop bit is accepted as a new start.

## Timing
- Reset values: data_out=0x00, data_valid=0, frame_err=0, parity_err=0, bussy=0, FSM=IDLE, sync flops=1.
- Start detect to bussy high: 3 src_clk cycles from the rx_in edge (2 sync + 1 register).
- data_valid / frame_err / parity_err assert 1 cycle after the tick of the final stop sample. All three are 1-cycle pulses.
- bussy drops in the same cycle as data_valid, or when leaving BREAK.
- Reset mid-frame: all outputs return to reset values immediately. The partial byte is lost.

## Configuration
- UART_RX_PARITY_EN: when defined, the frame has an even parity bit between data and stop; PARITY state exists and parity_err is live. When undefined, the frame is 8N1, there is no PARITY state, and parity_err is constant 0.

## Structure
- **Shared package uart_pkg:** state enum; baud rate constants; divisor function of (CLK_FREQ, baud, SCALE); default SCALE (mirrors SAMPLING_FACTOR).
- **Sub-module uart_rx_tick_gen:** divider with restart input and latched baud_sel, producing the oversample tick.
- The FSM, majority voter and shift register stay in uart_rx_oversample.

## Test plan
All scenarios use CLK_FREQ=50 MHz and baud_sel=11 (divisor 27) unless noted.
- **Clean byte:** frame 0xA5, 8N1 → exactly one data_valid, data_out=0xA5, frame_err=0, bussy low after the pulse.
- **False start:** rx_in low for 4 ticks, then high → no pulses, bussy returns 0 within one bit time, data_out unchanged.
- **Framing error:** frame 0x3C with stop=0, line held low 2 bit times → frame_err pulse, data_out keeps its prior 0xA5, next frame 0x5A (after the line returns high) → data_valid, 0x5A.
- **Glitch rejection:** frame 0xFF with one oversample-tick low glitch at the centre sample of bit 3 → data_out=0xFF, no errors.
- **Reset mid-frame:** rst_n low during bit 4 → outputs 0 at once; next frame 0x55 at baud_sel=00 (divisor 326) → data_out=0x55.
- **Back-to-back and parity:** frames 0x00, 0xFF with no idle gap → two data_valid pulses. With UART_RX_PARITY_EN, 0x01 sent with parity bit 0 → data_valid and parity_err in the same cycle.
